// File: rtl/ddr3_traffic_checker.sv
// Loopback traffic generator/checker for the DDR3 controller user port: writes N words, reads them back, compares in order.
// Optional read watchdog enabled by defining TRAFFIC_TIMEOUT_EN.
module ddr3_traffic_checker #(
    parameter int DQ_BITWIDTH           = 16,
    parameter int ADDRESS_BITWIDTH      = 15,
    parameter int BANK_ADDRESS_BITWIDTH = 3,
    parameter int NUM_OF_TRANSFERS      = 256,
    parameter int PATTERN_MODE          = 0,
    parameter int LFSR_SEED             = 1,
    parameter int ERR_COUNT_BITWIDTH    = 16,
    parameter int TIMEOUT_CYCLES        = 1024,
    localparam int UA = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          i_ready,
    output logic                          o_write_enable,
    output logic                          o_read_enable,
    output logic [UA-1:0]                 o_user_data_address,
    output logic [DQ_BITWIDTH-1:0]        o_user_data,
    input  logic [DQ_BITWIDTH-1:0]        i_user_data,
    input  logic                          i_user_data_valid,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_pass,
    output logic [ERR_COUNT_BITWIDTH-1:0] o_error_count,
    output logic [UA-1:0]                 o_first_error_address,
    output logic                          o_timeout,
    output logic [2:0]                    debug_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Maximal-length Fibonacci taps; other widths fall back to the two top bits.
    localparam logic [63:0] TAPS64 =
        (DQ_BITWIDTH == 8)  ? 64'h0000_0000_0000_00B8 :
        (DQ_BITWIDTH == 16) ? 64'h0000_0000_0000_D008 :
        (DQ_BITWIDTH == 32) ? 64'h0000_0000_8020_0003 :
        (DQ_BITWIDTH == 64) ? 64'hD800_0000_0000_0000 :
                              (64'd3 << (DQ_BITWIDTH - 2));
    localparam logic [DQ_BITWIDTH-1:0] TAPS     = TAPS64[DQ_BITWIDTH-1:0];
    localparam logic [DQ_BITWIDTH-1:0] SEED_VAL = DQ_BITWIDTH'(LFSR_SEED);
    localparam logic [DQ_BITWIDTH-1:0] GEN_INIT = (PATTERN_MODE == 1) ? SEED_VAL : '0;
    localparam logic [UA-1:0]          LAST_IDX = UA'(NUM_OF_TRANSFERS - 1);
    localparam logic [UA:0]            N_CNT    = (UA+1)'(NUM_OF_TRANSFERS);

    function automatic logic [DQ_BITWIDTH-1:0] gen_next(input logic [DQ_BITWIDTH-1:0] cur);
        if (PATTERN_MODE == 1)
            return {cur[DQ_BITWIDTH-2:0], ^(cur & TAPS)};
        else
            return cur + DQ_BITWIDTH'(1);
    endfunction

    state_t                        state, state_next;
    logic [UA-1:0]                 index;
    logic [DQ_BITWIDTH-1:0]        wr_gen, rd_gen;
    logic                          write_en, read_en;
    logic [UA:0]                   outstanding, resp_count;
    logic [ERR_COUNT_BITWIDTH-1:0] err_count;
    logic [UA-1:0]                 first_err_addr;
    logic                          pass_q, timeout_q, timeout_hit;
    logic                          wr_accept, rd_accept, counted, mismatch, start_ok, in_read_phase;

    assign in_read_phase = (state == READ) || (state == DRAIN);
    assign wr_accept     = write_en && i_ready;
    assign rd_accept     = read_en && i_ready;
    // Stray valids outside the read phase are dropped once nothing is outstanding.
    assign counted       = i_user_data_valid && ((outstanding != '0) || in_read_phase);
    assign mismatch      = counted && (i_user_data != rd_gen);
    assign start_ok      = start && ((state == IDLE) || (state == DONE));

`ifdef TRAFFIC_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_count;

    always_ff @(posedge clk) begin
        if (reset || start_ok || !in_read_phase || rd_accept || counted)
            wd_count <= '0;
        else
            wd_count <= wd_count + WD_W'(1);
    end

    assign timeout_hit = in_read_phase && !rd_accept && !counted &&
                         (wd_count == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = WRITE;
            WRITE:   if (wr_accept && (index == LAST_IDX)) state_next = READ;
            READ: begin
                if (timeout_hit)                             state_next = DONE;
                else if (rd_accept && (index == LAST_IDX))   state_next = DRAIN;
            end
            DRAIN:   if ((resp_count >= N_CNT) || timeout_hit) state_next = DONE;
            DONE:    if (start) state_next = WRITE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy      = (state == WRITE) || in_read_phase;
        o_done      = (state == DONE);
        debug_state = state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_en       <= 1'b0;
            read_en        <= 1'b0;
            index          <= '0;
            wr_gen         <= GEN_INIT;
            rd_gen         <= GEN_INIT;
            outstanding    <= '0;
            resp_count     <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            pass_q         <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            write_en <= (state_next == WRITE);
            // Entering READ leaves one idle command cycle before the first read.
            read_en  <= (state == READ) && (state_next == READ);
            if (start_ok) begin
                index          <= '0;
                wr_gen         <= GEN_INIT;
                rd_gen         <= GEN_INIT;
                outstanding    <= '0;
                resp_count     <= '0;
                err_count      <= '0;
                first_err_addr <= '0;
                pass_q         <= 1'b0;
                timeout_q      <= 1'b0;
            end else begin
                if (wr_accept || rd_accept)
                    index <= (index == LAST_IDX) ? '0 : index + UA'(1);
                if (wr_accept)
                    wr_gen <= gen_next(wr_gen);
                if (rd_accept && !counted)
                    outstanding <= outstanding + (UA+1)'(1);
                else if (!rd_accept && counted && (outstanding != '0))
                    outstanding <= outstanding - (UA+1)'(1);
                if (counted) begin
                    rd_gen     <= gen_next(rd_gen);
                    resp_count <= resp_count + (UA+1)'(1);
                end
                if (mismatch) begin
                    if (err_count == '0)
                        first_err_addr <= resp_count[UA-1:0];
                    if (err_count != '1)
                        err_count <= err_count + ERR_COUNT_BITWIDTH'(1);
                end
                if ((state != DONE) && (state_next == DONE)) begin
                    pass_q    <= (err_count == '0) && !timeout_hit;
                    timeout_q <= timeout_hit;
                end
            end
        end
    end

    assign o_write_enable        = write_en;
    assign o_read_enable         = read_en;
    assign o_user_data_address   = index;
    assign o_user_data           = write_en ? wr_gen : '0;
    assign o_pass                = pass_q;
    assign o_error_count         = err_count;
    assign o_first_error_address = first_err_addr;
    assign o_timeout             = timeout_q;

endmodule

// File: tb/tb_ddr3_traffic_checker.sv
// Bench for ddr3_traffic_checker: echo-memory controller model with 3-cycle read latency and a command scoreboard.
module tb_ddr3_traffic_checker;
    localparam int DQ = 16;
    localparam int UA = 18;
    localparam int W  = 1 + UA + DQ;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          start[2], ready[2], we[2], re[2], valid[2];
    logic          busy[2], done[2], pass[2], tmo[2];
    logic [UA-1:0] addr[2], ferr[2];
    logic [DQ-1:0] wdata[2], rdata[2];
    logic [15:0]   errc[2];
    logic [2:0]    dbg[2];

    ddr3_traffic_checker #(.NUM_OF_TRANSFERS(4), .PATTERN_MODE(0), .TIMEOUT_CYCLES(32)) u_inc (
        .clk(clk), .reset(reset), .start(start[0]), .i_ready(ready[0]),
        .o_write_enable(we[0]), .o_read_enable(re[0]), .o_user_data_address(addr[0]),
        .o_user_data(wdata[0]), .i_user_data(rdata[0]), .i_user_data_valid(valid[0]),
        .o_busy(busy[0]), .o_done(done[0]), .o_pass(pass[0]), .o_error_count(errc[0]),
        .o_first_error_address(ferr[0]), .o_timeout(tmo[0]), .debug_state(dbg[0]));

    ddr3_traffic_checker #(.NUM_OF_TRANSFERS(16), .PATTERN_MODE(1), .LFSR_SEED(1)) u_lfsr (
        .clk(clk), .reset(reset), .start(start[1]), .i_ready(ready[1]),
        .o_write_enable(we[1]), .o_read_enable(re[1]), .o_user_data_address(addr[1]),
        .o_user_data(wdata[1]), .i_user_data(rdata[1]), .i_user_data_valid(valid[1]),
        .o_busy(busy[1]), .o_done(done[1]), .o_pass(pass[1]), .o_error_count(errc[1]),
        .o_first_error_address(ferr[1]), .o_timeout(tmo[1]), .debug_state(dbg[1]));

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    int cur = 0;
    int corrupt[2];
    bit drop[2];
    bit stall[2];
    int neg_cyc = 0;
    int last_rd_cyc = 0;
    logic [3:0] pat = 4'b1001;

    logic [DQ-1:0] mem [2][16];
    bit            pv  [2][3];
    logic [DQ-1:0] pd  [2][3];
    bit            acc_w[2], acc_r[2];
    logic [UA-1:0] s_addr[2];
    logic [DQ-1:0] s_data[2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
    endfunction

    // Controller model and command monitor: sample at negedge, respond 1 time unit after posedge.
    initial begin
        for (int k = 0; k < 2; k++) begin
            ready[k] = 1'b1; valid[k] = 1'b0; rdata[k] = '0;
            for (int j = 0; j < 3; j++) begin pv[k][j] = 1'b0; pd[k][j] = '0; end
            for (int j = 0; j < 16; j++) mem[k][j] = '0;
        end
        forever begin
            @(negedge clk);
            neg_cyc++;
            for (int k = 0; k < 2; k++) begin
                acc_w[k]  = we[k] && ready[k];
                acc_r[k]  = re[k] && ready[k];
                s_addr[k] = addr[k];
                s_data[k] = wdata[k];
            end
            if (!reset && (we[cur] || re[cur])) begin
                if (exp_q.size() == 0)
                    check("extra_cmd", 64'(exp_q.size()), 64'd1);
                else begin
                    check("cmd", 64'({re[cur], addr[cur], (re[cur] ? 16'h0 : wdata[cur])}), 64'(exp_q[0]));
                    if (acc_w[cur] || acc_r[cur]) void'(exp_q.pop_front());
                end
            end
            if (acc_r[cur]) last_rd_cyc = neg_cyc;
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (reset) begin
                    for (int j = 0; j < 3; j++) pv[k][j] = 1'b0;
                    valid[k] = 1'b0;
                end else begin
                    if (acc_w[k]) mem[k][s_addr[k][3:0]] = s_data[k];
                    pv[k][2] = pv[k][1]; pd[k][2] = pd[k][1];
                    pv[k][1] = pv[k][0]; pd[k][1] = pd[k][0];
                    pv[k][0] = acc_r[k] && !drop[k];
                    pd[k][0] = (int'(s_addr[k]) == corrupt[k]) ? 16'h00FF : mem[k][s_addr[k][3:0]];
                    valid[k] = pv[k][2];
                    rdata[k] = pd[k][2];
                end
                ready[k] = stall[k] ? pat[neg_cyc % 4] : 1'b1;
            end
        end
    end

    task automatic push_expected(input int n, input bit lfsr);
        logic [15:0] d;
        exp_q.delete();
        d = lfsr ? 16'h0001 : 16'h0000;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b0, UA'(i), d});
            d = lfsr ? lfsr_step(d) : d + 16'd1;
        end
        for (int i = 0; i < n; i++) exp_q.push_back({1'b1, UA'(i), 16'h0});
    endtask

    task automatic pulse_start(input int k);
        @(posedge clk); #1 start[k] = 1'b1;
        @(posedge clk); #1 start[k] = 1'b0;
        @(negedge clk); #1;
        check("busy_after_start", 64'(busy[k]), 64'd1);
    endtask

    task automatic wait_done(input int k, output int seen_cyc);
        int n;
        n = 0;
        seen_cyc = 0;
        while (!done[k] && n < 600) begin
            @(negedge clk); #1;
            n++;
        end
        seen_cyc = neg_cyc;
        check("done_within_budget", 64'(done[k]), 64'd1);
    endtask

    task automatic run(input int k, input int n, input bit lfsr);
        int c;
        cur = k;
        push_expected(n, lfsr);
        pulse_start(k);
        wait_done(k, c);
    endtask

    task automatic check_result(input int k, input logic ep, input logic [15:0] ee,
                                input logic [UA-1:0] ef, input logic et);
        check("done", 64'(done[k]), 64'd1);
        check("busy_done", 64'(busy[k]), 64'd0);
        check("pass", 64'(pass[k]), 64'(ep));
        check("error_count", 64'(errc[k]), 64'(ee));
        check("first_error_address", 64'(ferr[k]), 64'(ef));
        check("timeout", 64'(tmo[k]), 64'(et));
        check("cmds_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag, input int k);
        check({tag, "_we"}, 64'(we[k]), 64'd0);
        check({tag, "_re"}, 64'(re[k]), 64'd0);
        check({tag, "_busy"}, 64'(busy[k]), 64'd0);
        check({tag, "_done"}, 64'(done[k]), 64'd0);
        check({tag, "_pass"}, 64'(pass[k]), 64'd0);
        check({tag, "_errc"}, 64'(errc[k]), 64'd0);
        check({tag, "_ferr"}, 64'(ferr[k]), 64'd0);
        check({tag, "_tmo"}, 64'(tmo[k]), 64'd0);
        check({tag, "_addr"}, 64'(addr[k]), 64'd0);
        check({tag, "_data"}, 64'(wdata[k]), 64'd0);
        check({tag, "_state"}, 64'(dbg[k]), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation still running at %0t", $time);
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        int dc;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0; corrupt[k] = -1; drop[k] = 1'b0; stall[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk); #1;
        check_idle_outputs("reset_inc", 0);
        check_idle_outputs("reset_lfsr", 1);

        // Incrementing pattern, clean echo
        run(0, 4, 1'b0);
        check_result(0, 1'b1, 16'd0, '0, 1'b0);

        // Corrupted read data at address 2
        corrupt[0] = 2;
        run(0, 4, 1'b0);
        check_result(0, 1'b0, 16'd1, UA'(2), 1'b0);

        // Reset in the middle of the read phase, with corruption still active
        cur = 0;
        push_expected(4, 1'b0);
        pulse_start(0);
        n = 0;
        while (!re[0] && n < 200) begin @(negedge clk); #1; n++; end
        check("reached_read", 64'(re[0]), 64'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        @(negedge clk); #1;
        check_idle_outputs("midread_reset", 0);
        corrupt[0] = -1;
        repeat (5) @(posedge clk);
        run(0, 4, 1'b0);
        check_result(0, 1'b1, 16'd0, '0, 1'b0);

        // Ready stalls 1-0-0-1: commands must hold and be accepted exactly once
        stall[0] = 1'b1;
        run(0, 4, 1'b0);
        check_result(0, 1'b1, 16'd0, '0, 1'b0);
        stall[0] = 1'b0;

        // LFSR pattern, 16 words
        run(1, 16, 1'b1);
        check_result(1, 1'b1, 16'd0, '0, 1'b0);
        cur = 0;

`ifdef TRAFFIC_TIMEOUT_EN
        // Controller never returns data: watchdog must end the pass
        drop[0] = 1'b1;
        cur = 0;
        push_expected(4, 1'b0);
        pulse_start(0);
        wait_done(0, dc);
        check("timeout_fired", 64'(tmo[0]), 64'd1);
        check("timeout_pass", 64'(pass[0]), 64'd0);
        check("timeout_done", 64'(done[0]), 64'd1);
        // Accept is sampled the cycle before its edge; DONE appears 32 edges after that edge.
        check("timeout_latency", 64'(dc - last_rd_cyc), 64'd33);
        drop[0] = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ddr3_traffic_checker.md
Name: ddr3_traffic_checker

Overview:
Parametrised loopback traffic generator and checker for the DDR3 memory controller user port. On start it writes a burst of NUM_OF_TRANSFERS words (incrementing or LFSR pattern) to consecutive user addresses, then reads them back. Returned data is compared in order against a regenerated expected stream. It reports pass/fail, a saturating error count and the first failing address, replacing the fixed 16-bit free-running loopback harness in board bring-up.

Parameters:
DQ_BITWIDTH, 16, user data width
ADDRESS_BITWIDTH, 15, DDR row/column address width
BANK_ADDRESS_BITWIDTH, 3, bank address width; user address width UA = BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH
NUM_OF_TRANSFERS, 256, words per pass, 1..2^UA
PATTERN_MODE, 0, 0 = incrementing data, 1 = Fibonacci LFSR data
LFSR_SEED, 1, LFSR start value, nonzero, truncated to DQ_BITWIDTH
ERR_COUNT_BITWIDTH, 16, error counter width
TIMEOUT_CYCLES, 1024, watchdog limit (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse, begins a pass
i_ready  in  1  controller accepts the presented command this cycle
o_write_enable  out  1  write command request
o_read_enable  out  1  read command request
o_user_data_address  out  UA  command address
o_user_data  out  DQ_BITWIDTH  write data
i_user_data  in  DQ_BITWIDTH  read data from controller
i_user_data_valid  in  1  read data valid, in request order
o_busy  out  1  pass in progress
o_done  out  1  pass finished, held until next start or reset
o_pass  out  1  valid when o_done; 1 = zero errors and no timeout
o_error_count  out  ERR_COUNT_BITWIDTH  mismatches, saturating at all-ones
o_first_error_address  out  UA  address of first mismatch, 0 if none
o_timeout  out  1  watchdog fired

Behaviour:
- Reset: state IDLE; every output 0; counters 0; generators reloaded.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE/DONE + start: clear error count, first-error address, o_pass, o_done and o_timeout; reload both generators; command index 0; enter WRITE next cycle. Start during WRITE/READ/DRAIN is ignored.
- WRITE: o_write_enable=1 with address = index and data = gen_value. A command is accepted when enable && i_ready. On accept: index+1 and generator advances. Command fields are held stable while i_ready=0. After accept of index N-1: enter READ, index reloads 0, enable drops for exactly one cycle.
- READ: o_read_enable=1, address = index; it advances on accept. After the last accept, enter DRAIN.
- Outstanding counter: +1 on read accept, -1 on valid, both together gives net 0. Valid is ignored when outstanding=0 and the state is not READ/DRAIN.
- Each counted valid compares i_user_data with the expected generator, then advances it. On mismatch: error count +1 (saturating). If this is the first error, latch the expected-stream address.
- DRAIN: when the response count reaches N, enter DONE. o_done=1, o_busy=0, o_pass=(errors==0)&&!o_timeout.
- o_busy=1 in WRITE/READ/DRAIN.
- Incrementing pattern: data = index truncated/zero-extended to DQ_BITWIDTH.
- LFSR pattern: maximal-length taps for DQ_BITWIDTH 8/16/32/64. Shifts once per accepted write, or per compared read for the expected copy.
- Address arithmetic is modulo 2^UA. Wrap at N=2^UA is legal.
- Enables are registered outputs. A command's data/address changes only the cycle after its accept.

Optional Feature:
TRAFFIC_TIMEOUT_EN: defined: a watchdog counts cycles in READ/DRAIN since the last valid or last read accept. At TIMEOUT_CYCLES it forces DONE with o_timeout=1 and o_pass=0. Undefined: no watchdog; o_timeout is tied 0 and the block waits indefinitely.

Test Plan:
- N=4, PATTERN_MODE=0, i_ready=1, controller model echoes writes with 3-cycle read latency -> writes to addresses 0..3 with data 0x0000..0x0003, reads 0..3, o_done=1, o_pass=1, o_error_count=0.
- Same, model corrupts address 2 data to 0x00FF -> o_pass=0, o_error_count=1, o_first_error_address=2.
- i_ready toggled 1-0-0-1 during WRITE -> address/data held during stalls; exactly 4 writes accepted, no duplicates.
- PATTERN_MODE=1, LFSR_SEED=1, N=16 with echo model -> write data follows the LFSR sequence from 0x0001; o_pass=1.
- Reset asserted mid-READ -> next cycle all outputs 0, state IDLE; a following start gives a clean pass.
- TRAFFIC_TIMEOUT_EN, TIMEOUT_CYCLES=32, model never returns data -> 32 cycles after the last read accept: o_done=1, o_timeout=1, o_pass=0.
